alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the number of cycles (1..15) operands are held on the ALU before the result is captured.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 opcode: 0 AND, 1 OR, 2 NAND, 3 XOR, 4 ADD, 5 SUB, 6 MUL, 7 DIV.
REQ-008 rsp0_valid  output  1  result for requester 0 available.
REQ-009 rsp0_ready  input  1  requester 0 consumes result.
REQ-010 rsp0_data  output  8  result for requester 0.
REQ-011 rsp0_err  output  1  error flag for requester 0.
REQ-012 req1_*/rsp1_* SHALL be identical to REQ-004..REQ-011, for requester 1.
REQ-013 alu_a, alu_b  output  4 each; alu_op  output  3: operands and opcode driven to the shared combinational ALU.
REQ-014 alu_out  input  8  ALU result.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-016 IDLE: req_ready SHALL be combinational and asserted only for the granted requester with valid high; a valid&&ready edge SHALL latch a/b/op and the granted index, then move to ISSUE.
REQ-017 Arbitration SHALL be two-way round-robin: the last-granted pointer flips on each accept; with both requesters valid, the one not last granted wins; a single valid requester always wins.
REQ-018 ISSUE SHALL drive the latched operands on alu_a/alu_b/alu_op for exactly SETTLE_CYCLES cycles; on the final ISSUE edge alu_out SHALL be captured into the granted rsp_data and the FSM SHALL move to RESP.
REQ-019 Latency: rsp_valid SHALL rise SETTLE_CYCLES edges after the accepting edge.
REQ-020 RESP: only the granted rsp_valid SHALL be high, with rsp_data/rsp_err stable until rsp_ready; the handshake edge SHALL clear rsp_valid and return to IDLE.
REQ-021 No new request SHALL be accepted outside IDLE; minimum throughput is one operation per SETTLE_CYCLES+2 cycles.
REQ-022 alu_a, alu_b and alu_op SHALL be 0 outside ISSUE.
REQ-023 A requester dropping valid before acceptance SHALL NOT be granted; nothing is retained for it.
REQ-024 A backpressured response (rsp_ready low) SHALL stall the arbiter indefinitely with no data change.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state IDLE, every ready/valid/data/err output 0, alu_* 0, and the pointer so that requester 0 wins the first tie.
REQ-026 Reset mid-ISSUE or mid-RESP SHALL discard the operation; no response is produced after release.

Configuration
REQ-027 With ALU_ARB_DIVZERO_CHK_EN defined, an accepted op 7 with b==0 SHALL skip ISSUE and go to RESP on the next edge with rsp_data 8'hFF, rsp_err 1, alu_* kept 0.
REQ-028 Without ALU_ARB_DIVZERO_CHK_EN, division by zero SHALL be issued like any other op and both rsp_err outputs SHALL be tied 0.

Structure
REQ-029 Package alu_arb_pkg SHALL hold opcode constants OP_AND..OP_DIV, the state enum, and operand/result width constants (4, 8).
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: two valids, pointer; outputs: one-hot grant).

Verification
REQ-031 Single request: req0 a=3, b=5, op=6, SETTLE_CYCLES=1 -> req0_ready for 1 cycle, alu_op=6 for 1 cycle, rsp0_valid next cycle with rsp0_data 8'h0F.
REQ-032 Simultaneous: both valid after reset, req0 ADD 9+8, req1 AND 4'hC&4'hA -> req0 served first (8'h11), then req1 (8'h08); a second tie grants req0 again.
REQ-033 Backpressure: rsp1_ready held low 10 cycles -> rsp1_valid/rsp1_data stable, req0_ready stays 0, and completion follows rsp1_ready.
REQ-034 Reset mid-ISSUE (SETTLE_CYCLES=4, rst_n low in cycle 2) -> all outputs 0 immediately, no rsp_valid after release.
REQ-035 Divide by zero: req0 a=7, b=0, op=7 -> with macro: rsp0_data 8'hFF, rsp0_err 1, alu_op never 7; without macro: alu_op=7 issued, rsp0_err 0.
REQ-036 Withdrawn request: req1_valid pulses for one cycle while the arbiter is in RESP -> req1 is never granted and no rsp1_valid appears.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - operand / result widths
//   - ALU opcode constants OP_AND .. OP_DIV
//   - FSM state enum (IDLE, ISSUE, RESP)
//   - is_divzero() helper used when ALU_ARB_DIVZERO_CHK_EN is defined
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int OPW  = 4;  // operand width
  localparam int RESW = 8;  // result width
  localparam int OPCW = 3;  // opcode width

  localparam logic [OPCW-1:0] OP_AND  = 3'd0;
  localparam logic [OPCW-1:0] OP_OR   = 3'd1;
  localparam logic [OPCW-1:0] OP_NAND = 3'd2;
  localparam logic [OPCW-1:0] OP_XOR  = 3'd3;
  localparam logic [OPCW-1:0] OP_ADD  = 3'd4;
  localparam logic [OPCW-1:0] OP_SUB  = 3'd5;
  localparam logic [OPCW-1:0] OP_MUL  = 3'd6;
  localparam logic [OPCW-1:0] OP_DIV  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // True for a divide whose divisor is zero.
  function automatic logic is_divzero(input logic [OPCW-1:0] op,
                                      input logic [OPW-1:0]  b);
    return (op == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic (purely combinational).
//   valid0, valid1 : request valids
//   last           : index of the most recently granted requester
//   grant[1:0]     : one-hot grant (all zero when nobody is valid)
// A lone valid requester always wins; on a tie the requester that was not
// granted last wins.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid0 & (~valid1 | last);
    grant[1] = valid1 & (~valid0 | ~last);
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters.
//
// Parameter SETTLE_CYCLES (1..15): cycles operands are held on alu_* before
// alu_out is captured.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           request handshake (N = 0,1)
//   reqN_a, reqN_b, reqN_op    request operands / opcode
//   rspN_valid/ready           response handshake
//   rspN_data, rspN_err        response result / error flag
//   alu_a, alu_b, alu_op       drive to the shared ALU (0 outside ISSUE)
//   alu_out                    ALU result
//   dbg_state                  current FSM state
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. reqN_ready is combinational (IDLE and granted); valid must
// not depend on ready. rspN_valid holds with stable data until rspN_ready.
//
// Optional feature ALU_ARB_DIVZERO_CHK_EN: a divide by zero is answered
// directly with 8'hFF and rspN_err=1 without touching the ALU. When the
// macro is undefined such ops are issued normally and rspN_err is tied 0.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic [OPCW-1:0] req0_op,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [RESW-1:0] rsp0_data,
  output logic            rsp0_err,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  input  logic [OPCW-1:0] req1_op,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [RESW-1:0] rsp1_data,
  output logic            rsp1_err,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [OPCW-1:0] alu_op,
  input  logic [RESW-1:0] alu_out,
  output state_t          dbg_state
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic            last_idx;   // 1: requester 1 was granted most recently
  logic            cur_idx;    // requester owning the operation in flight
  logic [OPW-1:0]  op_a, op_b;
  logic [OPCW-1:0] op_code;
  logic [RESW-1:0] res_q;

  logic [1:0]      grant;
  logic            accept;
  logic            acc_idx;
  logic [OPW-1:0]  acc_a, acc_b;
  logic [OPCW-1:0] acc_op;
  logic            acc_dz;
  logic            settle_done;
  logic            rsp_hs;

  rr_arb2 u_rr_arb2 (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last_idx),
    .grant  (grant)
  );

  // Request side: only offer ready in IDLE.
  always_comb begin
    req0_ready = (state == IDLE) & grant[0];
    req1_ready = (state == IDLE) & grant[1];
  end

  assign accept  = req0_ready | req1_ready;
  assign acc_idx = req1_ready;
  assign acc_a   = acc_idx ? req1_a  : req0_a;
  assign acc_b   = acc_idx ? req1_b  : req0_b;
  assign acc_op  = acc_idx ? req1_op : req0_op;

`ifdef ALU_ARB_DIVZERO_CHK_EN
  assign acc_dz = is_divzero(acc_op, acc_b);
`else
  assign acc_dz = 1'b0;
`endif

  assign settle_done = (cnt == LAST_CNT);
  assign rsp_hs      = cur_idx ? rsp1_ready : rsp0_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)      state_nx = acc_dz ? RESP : ISSUE;
      ISSUE:   if (settle_done) state_nx = RESP;
      RESP:    if (rsp_hs)      state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // Datapath: latch on accept, count settle cycles, capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      last_idx <= 1'b1;  // requester 0 wins the first tie
      cur_idx  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        op_a     <= acc_a;
        op_b     <= acc_b;
        op_code  <= acc_op;
        cur_idx  <= acc_idx;
        last_idx <= acc_idx;
        cnt      <= '0;
        if (acc_dz) res_q <= 8'hFF;
      end
      if (state == ISSUE) begin
        cnt <= cnt + 4'd1;
        if (settle_done) res_q <= alu_out;
      end
    end
  end

`ifdef ALU_ARB_DIVZERO_CHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= acc_dz;
    end
  end
`endif

  // Output decode
  always_comb begin
    alu_a      = (state == ISSUE) ? op_a    : '0;
    alu_b      = (state == ISSUE) ? op_b    : '0;
    alu_op     = (state == ISSUE) ? op_code : '0;
    rsp0_valid = (state == RESP) & ~cur_idx;
    rsp1_valid = (state == RESP) &  cur_idx;
    rsp0_data  = rsp0_valid ? res_q : '0;
    rsp1_data  = rsp1_valid ? res_q : '0;
`ifdef ALU_ARB_DIVZERO_CHK_EN
    rsp0_err   = rsp0_valid & err_q;
    rsp1_err   = rsp1_valid & err_q;
`else
    rsp0_err   = 1'b0;
    rsp1_err   = 1'b0;
`endif
    dbg_state  = state;
  end

endmodule
